// File: rtl/balanca_pkg.sv
// Shared types and constants for the Balanca cents-to-euros price path.
package balanca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int unsigned DIVISOR = 100;
  localparam int unsigned FRAC_W  = 7;

  // Integer-euros width: 2^cent_w / 100 always fits in cent_w-6 bits.
  function automatic int unsigned euro_w(input int unsigned cent_w);
    return cent_w - 6;
  endfunction

endpackage

// File: rtl/bin2bcd_2dig.sv
// Combinational 0..99 binary to two-digit BCD (tens in [7:4], units in [3:0]).
module bin2bcd_2dig (
  input  logic [6:0] bin,
  output logic [7:0] bcd
);

  // Constant-divisor split into decimal digits.
  always_comb begin
    bcd = {4'(bin / 7'd10), 4'(bin % 7'd10)};
  end

endmodule

// File: rtl/centimos_euros_seq.sv
// Sequential cents-to-euros converter: restoring divide-by-100, one quotient
// bit per clock, start/ready/done handshake.
// Optional macro BCD_FRAC_EN adds the registered fracao_bcd output.
module centimos_euros_seq
  import balanca_pkg::*;
#(
  parameter  int unsigned CENT_W = 14,
  localparam int unsigned EURO_W = euro_w(CENT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CENT_W-1:0] centimos,
  output logic              ready,
  output logic              done,
  output logic [EURO_W-1:0] euros_inteiros,
  output logic [FRAC_W-1:0] euros_fracao
`ifdef BCD_FRAC_EN
  ,
  output logic [7:0]        fracao_bcd
`endif
);

  localparam int unsigned CNT_W = $clog2(CENT_W);

  state_t              state;
  state_t              state_next;
  logic                load_c;
  logic                step_c;
  logic                fin_c;

  // dq holds the dividend on load; quotient bits enter at the LSB as the
  // dividend leaves at the MSB, so after CENT_W steps it is the quotient.
  logic [CENT_W-1:0]   dq;
  logic [FRAC_W-1:0]   rem;
  logic [CNT_W-1:0]    cnt;

  logic [FRAC_W:0]     rem_shift_c;
  logic                q_bit_c;
  logic [FRAC_W-1:0]   rem_next_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = DIV;
      DIV:     if (cnt == CNT_W'(CENT_W - 1)) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control decode from the current state.
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    fin_c  = 1'b0;
    unique case (state)
      IDLE:    load_c = start;
      DIV:     step_c = 1'b1;
      FIN:     fin_c  = 1'b1;
      default: ;
    endcase
  end

  // One restoring step; the incoming remainder is <= 99 so the shifted value fits 8 bits.
  always_comb begin
    rem_shift_c = {rem, dq[CENT_W-1]};
    q_bit_c     = (rem_shift_c >= 8'(DIVISOR));
    rem_next_c  = q_bit_c ? FRAC_W'(rem_shift_c - 8'(DIVISOR))
                          : rem_shift_c[FRAC_W-1:0];
  end

`ifdef BCD_FRAC_EN
  logic [7:0] bcd_c;

  bin2bcd_2dig u_bin2bcd (
    .bin (rem),
    .bcd (bcd_c)
  );
`endif

  // Divide datapath, handshake flags and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq             <= '0;
      rem            <= '0;
      cnt            <= '0;
      ready          <= 1'b1;
      done           <= 1'b0;
      euros_inteiros <= '0;
      euros_fracao   <= '0;
`ifdef BCD_FRAC_EN
      fracao_bcd     <= '0;
`endif
    end else begin
      ready <= (state_next == IDLE);
      done  <= fin_c;
      if (load_c) begin
        dq  <= centimos;
        rem <= '0;
        cnt <= '0;
      end else if (step_c) begin
        dq  <= {dq[CENT_W-2:0], q_bit_c};
        rem <= rem_next_c;
        cnt <= cnt + CNT_W'(1);
      end
      if (fin_c) begin
        euros_inteiros <= dq[EURO_W-1:0];
        euros_fracao   <= rem;
`ifdef BCD_FRAC_EN
        fracao_bcd     <= bcd_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_centimos_euros_seq.sv
// Self-checking bench for centimos_euros_seq (CENT_W=14 main instance plus a
// CENT_W=20 instance for the wide case).
module tb_centimos_euros_seq;

  localparam int unsigned CW   = 14;
  localparam int unsigned EW   = CW - 6;
  localparam int unsigned CW2  = 20;
  localparam int unsigned EW2  = CW2 - 6;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [CW-1:0]  centimos;
  logic           ready;
  logic           done;
  logic [EW-1:0]  euros_inteiros;
  logic [6:0]     euros_fracao;
`ifdef BCD_FRAC_EN
  logic [7:0]     fracao_bcd;
`endif

  logic           start2;
  logic [CW2-1:0] centimos2;
  logic           ready2;
  logic           done2;
  logic [EW2-1:0] euros_inteiros2;
  logic [6:0]     euros_fracao2;
`ifdef BCD_FRAC_EN
  logic [7:0]     fracao_bcd2;
`endif

  int tests = 0;
  int fails = 0;

  centimos_euros_seq #(.CENT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .centimos       (centimos),
    .ready          (ready),
    .done           (done),
    .euros_inteiros (euros_inteiros),
    .euros_fracao   (euros_fracao)
`ifdef BCD_FRAC_EN
    ,
    .fracao_bcd     (fracao_bcd)
`endif
  );

  centimos_euros_seq #(.CENT_W(CW2)) dut20 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start2),
    .centimos       (centimos2),
    .ready          (ready2),
    .done           (done2),
    .euros_inteiros (euros_inteiros2),
    .euros_fracao   (euros_fracao2)
`ifdef BCD_FRAC_EN
    ,
    .fracao_bcd     (fracao_bcd2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  // Reference: plain integer division of the amount in cents.
  task automatic check_result(input string tag, input int unsigned c);
    chk({tag, "_euros"}, 32'(euros_inteiros), c / 100);
    chk({tag, "_frac"}, 32'(euros_fracao), c % 100);
`ifdef BCD_FRAC_EN
    chk({tag, "_bcd"}, 32'(fracao_bcd), (((c % 100) / 10) << 4) | ((c % 100) % 10));
`endif
  endtask

  task automatic convert(input string tag, input int unsigned c);
    int edges;
    @(negedge clk);
    chk({tag, "_ready_idle"}, 32'(ready), 1);
    start    = 1'b1;
    centimos = CW'(c);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    centimos = CW'($urandom);
    chk({tag, "_ready_busy"}, 32'(ready), 0);
    wait_done(edges);
    chk({tag, "_latency"}, 32'(edges), CW + 1);
    check_result(tag, c);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    int edges;
    int npulse;
    int t_first;
    int t_second;
    int unsigned v1e, v1f, v2e, v2f;
    int unsigned r;

    rst_n     = 1'b0;
    start     = 1'b0;
    centimos  = '0;
    start2    = 1'b0;
    centimos2 = '0;
    #12;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_euros", 32'(euros_inteiros), 0);
    chk("rst_frac", 32'(euros_fracao), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed values and boundaries.
    convert("c470", 470);
    convert("c0", 0);
    convert("c99", 99);
    convert("c100", 100);
    convert("cmax", (1 << CW) - 1);

    // Start pulses during DIV are ignored; exactly one done.
    @(negedge clk);
    start    = 1'b1;
    centimos = CW'(1234);
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    npulse  = 0;
    t_first = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i >= 3 && i < 6) begin
        start    = 1'b1;
        centimos = CW'(250);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        npulse++;
        if (npulse == 1) begin
          t_first = i;
          v1e = 32'(euros_inteiros);
          v1f = 32'(euros_fracao);
        end
      end
    end
    start = 1'b0;
    chk("ign_pulses", 32'(npulse), 1);
    chk("ign_latency", 32'(t_first), CW + 1);
    chk("ign_euros", v1e, 12);
    chk("ign_frac", v1f, 34);

    // Start held high: back-to-back conversions.
    @(negedge clk);
    start    = 1'b1;
    centimos = CW'(101);
    @(posedge clk);
    @(negedge clk);
    centimos = CW'(9999);
    npulse   = 0;
    t_first  = 0;
    t_second = 0;
    for (int i = 1; i <= 34; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b_ready_idle_only", 32'(ready), 32'(done));
      if (done) begin
        npulse++;
        if (npulse == 1) begin
          t_first = i;
          v1e = 32'(euros_inteiros);
          v1f = 32'(euros_fracao);
        end else if (npulse == 2) begin
          t_second = i;
          v2e = 32'(euros_inteiros);
          v2f = 32'(euros_fracao);
        end
      end
    end
    start = 1'b0;
    chk("b2b_pulses", 32'(npulse), 2);
    chk("b2b_first_at", 32'(t_first), CW + 1);
    chk("b2b_spacing", 32'(t_second - t_first), CW + 2);
    chk("b2b_1_euros", v1e, 1);
    chk("b2b_1_frac", v1f, 1);
    chk("b2b_2_euros", v2e, 99);
    chk("b2b_2_frac", v2f, 99);
    wait_done(edges);
    check_result("b2b_3", 9999);

    // Reset mid-DIV aborts and clears outputs.
    @(negedge clk);
    start    = 1'b1;
    centimos = CW'(5000);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_euros", 32'(euros_inteiros), 0);
    chk("abort_frac", 32'(euros_fracao), 0);
    chk("abort_ready", 32'(ready), 1);
    chk("abort_done", 32'(done), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("abort_no_done", 32'(npulse), 0);
    convert("c5000", 5000);

    // Randomized amounts against the arithmetic reference.
    for (int k = 0; k < 20; k++) begin
      r = $urandom_range((1 << CW) - 1, 0);
      convert($sformatf("rnd%0d_%0d", k, r), r);
    end

    // Wide instance, maximum amount.
    @(negedge clk);
    start2    = 1'b1;
    centimos2 = CW2'((1 << CW2) - 1);
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    edges  = 0;
    while (edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done2) break;
    end
    chk("w20_latency", 32'(edges), CW2 + 1);
    chk("w20_euros", 32'(euros_inteiros2), ((1 << CW2) - 1) / 100);
    chk("w20_frac", 32'(euros_fracao2), ((1 << CW2) - 1) % 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
